// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with programmable modulus, step, load/clear and wrap flags.
// Build option: define COUNTER_SATURATE_EN to hold at 0 / MAX_VAL instead of wrapping.
`timescale 1ns/1ps

module mod_updown_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MOD_N  = WIDTH'(MAX_VAL + 32'd1);
    localparam logic [WIDTH-1:0] RST_N  = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH:0]   sum_s;

    // Next-state selection: clear > load > enable > hold.
    always_comb begin
        sum_s   = {1'b0, count_q} + {1'b0, STEP_N};
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = RST_N;
            ovf_d   = 1'b0;
        end else if (load_i) begin
            if (load_val_i > MAX_N) begin
                count_d = MAX_N;
            end else begin
                count_d = load_val_i;
            end
        end else if (en_i) begin
            if (up_i) begin
                if (sum_s > MAX_W) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
                    count_d = MAX_N;
`else
                    // Wrapped value is below 2**WIDTH, so modulo-2**WIDTH arithmetic is exact.
                    count_d = count_q + STEP_N - MOD_N;
`endif
                end else begin
                    count_d = sum_s[WIDTH-1:0];
                end
            end else begin
                if (count_q < STEP_N) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
                    count_d = {WIDTH{1'b0}};
`else
                    count_d = count_q - STEP_N + MOD_N;
`endif
                end else begin
                    count_d = count_q - STEP_N;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= RST_N;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o  = count_q;
    assign tc_o     = tc_q;
    assign ovf_o    = ovf_q;
    assign at_max_o = (count_q == MAX_N);
    assign at_min_o = (count_q == {WIDTH{1'b0}});

endmodule
